// File: rtl/boardman_v2_uart_rx.sv
// rtl/boardman_v2_uart_rx.sv - 8N1 UART receiver with 16x fractional baud tick and FWFT byte FIFO
`timescale 1ns/1ps

module boardman_v2_uart_rx #(
    parameter int unsigned CLOCK_RATE      = 100000000,
    parameter int unsigned BAUD_RATE       = 1000000,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       frame_err,
    output logic       overflow,
    output logic       break_det
);

    // Accumulator increment: round(1024 * 16 * BAUD / CLOCK), computed wide to avoid overflow.
    localparam logic [63:0] INC_WIDE = (64'(16384) * 64'(BAUD_RATE) + 64'(CLOCK_RATE / 2))
                                       / 64'(CLOCK_RATE);
    localparam logic [10:0] INC      = INC_WIDE[10:0];
    localparam int unsigned L        = FIFO_DEPTH_LOG2;
    localparam int unsigned DEPTH    = 1 << FIFO_DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic         rx_s1_q;
    logic         rx_s2_q;
    logic         rxs;
    logic         rx_prev_q;
    logic [10:0]  acc_q;
    logic [10:0]  acc_d;
    logic         tick;

    state_t       state_q;
    logic [3:0]   tc_q;
    logic         s6_q;
    logic         s7_q;
    logic         maj;
    logic [2:0]   bit_idx_q;
    logic [7:0]   shreg_q;
    logic         push_q;
    logic [7:0]   push_data_q;
    logic         frame_err_q;
    logic         break_det_q;

    logic [7:0]   mem_q [DEPTH];
    logic [L:0]   wr_ptr_q;
    logic [L:0]   rd_ptr_q;
    logic         empty;
    logic         full;
    logic         pop;
    logic         push_ok;

    assign rxs = rx_s2_q;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= RX;
            rx_s2_q <= rx_s1_q;
        end
    end

    // Free-running fractional accumulator; bit 10 is a one-cycle 16x baud tick.
    assign acc_d = {1'b0, acc_q[9:0]} + INC;
    assign tick  = acc_q[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Previous line level as seen on ticks; starts low so a line held low out of reset cannot start a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q <= 1'b0;
        end else if (tick) begin
            rx_prev_q <= rxs;
        end
    end

    // Majority of the samples taken at tc=6, tc=7 and the current one at tc=8.
    assign maj = (s6_q & s7_q) | (s6_q & rxs) | (s7_q & rxs);

    // Receive FSM: start qualification, LSB-first shift, stop check, break hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tc_q        <= '0;
            s6_q        <= 1'b1;
            s7_q        <= 1'b1;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            frame_err_q <= 1'b0;
            break_det_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            if (tick) begin
                tc_q <= tc_q + 4'd1;
                if (tc_q == 4'd6) begin
                    s6_q <= rxs;
                end
                if (tc_q == 4'd7) begin
                    s7_q <= rxs;
                end
                case (state_q)
                    S_IDLE: begin
                        // The detecting tick is tc=0, so the next tick is tc=1.
                        if (rx_prev_q && !rxs) begin
                            state_q <= S_START;
                            tc_q    <= 4'd1;
                        end
                    end
                    S_START: begin
                        if (tc_q == 4'd8) begin
                            if (!maj) begin
                                state_q   <= S_DATA;
                                bit_idx_q <= '0;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    S_DATA: begin
                        if (tc_q == 4'd8) begin
                            shreg_q   <= {maj, shreg_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
                                state_q <= S_STOP;
                            end
                        end
                    end
                    S_STOP: begin
                        // Leaving at mid-stop-bit keeps the next start edge within 1/16 bit.
                        if (tc_q == 4'd8) begin
                            if (maj) begin
                                push_q      <= 1'b1;
                                push_data_q <= shreg_q;
                                state_q     <= S_IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                break_det_q <= 1'b1;
                                state_q     <= S_BREAK;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (rxs) begin
                            break_det_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // FIFO status: pointers carry one extra wrap bit to separate full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[L] != rd_ptr_q[L]) && (wr_ptr_q[L-1:0] == rd_ptr_q[L-1:0]);
    assign pop     = !empty && m_axis_tready;
    assign push_ok = push_q && (!full || pop);

    // FIFO pointer update; a full FIFO popped in the same cycle still accepts the push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[L-1:0]] <= push_data_q;
        end
    end

    assign m_axis_tdata  = empty ? 8'h00 : mem_q[rd_ptr_q[L-1:0]];
    assign m_axis_tvalid = !empty;
    assign frame_err     = frame_err_q;
    assign overflow      = push_q && full && !pop;
    assign break_det     = break_det_q;

endmodule

// File: tb/tb_boardman_v2_uart_rx.sv
// tb/tb_boardman_v2_uart_rx.sv - directed bench for boardman_v2_uart_rx
`timescale 1ns/1ps

module tb_boardman_v2_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       frame_err;
    logic       overflow;
    logic       break_det;

    int nvec  = 0;
    int nfail = 0;

    logic [7:0] rx_q [$];
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int both_cnt = 0;

    boardman_v2_uart_rx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .RX            (rx),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .frame_err     (frame_err),
        .overflow      (overflow),
        .break_det     (break_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log accepted beats and error pulses away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tvalid && tready) rx_q.push_back(tdata);
            if (frame_err) fe_cnt++;
            if (overflow) ov_cnt++;
            if (frame_err && overflow) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 frame; RX is left at the stop level.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop;
        #(bit_ns);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int base_n;
        int base_fe;
        int base_ov;
        logic [7:0] exp_b;

        rst_n  = 1'b0;
        rx     = 1'b1;
        tready = 1'b0;
        #21;
        check("reset_tvalid", 32'(tvalid), 32'd0);
        check("reset_tdata", 32'(tdata), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_break_det", 32'(break_det), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #2000;

        // T1: single byte with consumer ready
        tready = 1'b1;
        base_n = rx_q.size(); base_fe = fe_cnt; base_ov = ov_cnt;
        send_byte(8'hA5, 1'b1, 1000);
        #2000;
        check("t1_count", 32'(rx_q.size() - base_n), 32'd1);
        check("t1_data", 32'(rx_q[base_n]), 32'hA5);
        check("t1_no_fe", 32'(fe_cnt - base_fe), 32'd0);
        check("t1_no_ov", 32'(ov_cnt - base_ov), 32'd0);
        check("t1_tvalid_low", 32'(tvalid), 32'd0);

        // T2: back-to-back frames held in the FIFO, then released
        @(posedge clk); #1 tready = 1'b0;
        base_n = rx_q.size();
        send_byte(8'h00, 1'b1, 1000);
        send_byte(8'hFF, 1'b1, 1000);
        send_byte(8'h55, 1'b1, 1000);
        #2000;
        check("t2_tvalid_held", 32'(tvalid), 32'd1);
        check("t2_head_stable", 32'(tdata), 32'h00);
        check("t2_none_popped", 32'(rx_q.size() - base_n), 32'd0);
        @(posedge clk); #1 tready = 1'b1;
        #200;
        check("t2_count", 32'(rx_q.size() - base_n), 32'd3);
        check("t2_b0", 32'(rx_q[base_n]), 32'h00);
        check("t2_b1", 32'(rx_q[base_n + 1]), 32'hFF);
        check("t2_b2", 32'(rx_q[base_n + 2]), 32'h55);
        check("t2_empty", 32'(tvalid), 32'd0);

        // T3: bad stop bit followed by a held-low line
        base_n = rx_q.size(); base_fe = fe_cnt;
        send_byte(8'h3C, 1'b0, 1000);
        #50000;
        check("t3_frame_err", 32'(fe_cnt - base_fe), 32'd1);
        check("t3_break_det", 32'(break_det), 32'd1);
        check("t3_no_push", 32'(rx_q.size() - base_n), 32'd0);
        rx = 1'b1;
        #2000;
        check("t3_break_clear", 32'(break_det), 32'd0);
        send_byte(8'h3C, 1'b1, 1000);
        #2000;
        check("t3_recv_count", 32'(rx_q.size() - base_n), 32'd1);
        check("t3_recv_data", 32'(rx_q[base_n]), 32'h3C);
        check("t3_single_fe", 32'(fe_cnt - base_fe), 32'd1);

        // T4: overflow on the 17th byte with consumer stalled
        @(posedge clk); #1 tready = 1'b0;
        base_n = rx_q.size(); base_ov = ov_cnt;
        for (int i = 1; i <= 17; i++) begin
            send_byte(8'(i), 1'b1, 1000);
        end
        #2000;
        check("t4_overflow", 32'(ov_cnt - base_ov), 32'd1);
        check("t4_tvalid", 32'(tvalid), 32'd1);
        check("t4_head", 32'(tdata), 32'h01);
        @(posedge clk); #1 tready = 1'b1;
        #1000;
        check("t4_drain_count", 32'(rx_q.size() - base_n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            exp_b = 8'(i + 1);
            check($sformatf("t4_drain_%0d", i), 32'(rx_q[base_n + i]), 32'(exp_b));
        end

        // T5: start glitch and a line held low through reset release
        base_n = rx_q.size(); base_fe = fe_cnt;
        rx = 1'b0;
        #300;
        rx = 1'b1;
        #3000;
        rx = 1'b0;
        do_reset();
        #3000;
        rx = 1'b1;
        #3000;
        check("t5_no_byte", 32'(rx_q.size() - base_n), 32'd0);
        check("t5_no_fe", 32'(fe_cnt - base_fe), 32'd0);
        check("t5_no_break", 32'(break_det), 32'd0);
        send_byte(8'h96, 1'b1, 970);
        #2000;
        send_byte(8'h96, 1'b1, 1030);
        #2000;
        check("t5_baud_count", 32'(rx_q.size() - base_n), 32'd2);
        check("t5_fast", 32'(rx_q[base_n]), 32'h96);
        check("t5_slow", 32'(rx_q[base_n + 1]), 32'h96);

        // T6: reset during bit 4 with a byte already queued
        @(posedge clk); #1 tready = 1'b0;
        send_byte(8'h5A, 1'b1, 1000);
        #2000;
        check("t6_preload", 32'(tvalid), 32'd1);
        base_n = rx_q.size();
        exp_b = 8'hC3;
        rx = 1'b0;
        #1000;
        for (int i = 0; i < 4; i++) begin
            rx = exp_b[i];
            #1000;
        end
        rx = exp_b[4];
        #500;
        rst_n = 1'b0;
        #1;
        check("t6_tvalid_reset", 32'(tvalid), 32'd0);
        #100;
        rx = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #3000;
        @(posedge clk); #1 tready = 1'b1;
        send_byte(8'hC3, 1'b1, 1000);
        #2000;
        check("t6_count", 32'(rx_q.size() - base_n), 32'd1);
        check("t6_data", 32'(rx_q[base_n]), 32'hC3);
        check("never_coincide", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
